// File: rtl/instr_sequencer.sv
// Multicycle instruction sequencer: walks each instruction through fetch/decode/
// execute/memory/write-back, handshakes with I/D memory, traps and counts retires.
module instr_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Run,
  input  logic [6:0]  OpCode,
  input  logic        IMemReady,
  input  logic        DMemReady,
  output logic        IMemReq,
  output logic        IRWr,
  output logic        DMemReq,
  output logic        DMemWr,
  output logic        RUWrEn,
  output logic        PCWr,
  output logic        Trap,
  output logic [2:0]  State,
  output logic [31:0] InstRet
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WLAST = CW'(TIMEOUT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] wcnt;
  logic          retire;
  logic          legal;
  logic          is_load, is_store;

  assign is_load  = (OpCode == OP_LOAD);
  assign is_store = (OpCode == OP_STORE);

  always_comb begin
    legal = 1'b0;
    case (OpCode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt     = state;
    IMemReq = 1'b0;
    IRWr    = 1'b0;
    DMemReq = 1'b0;
    DMemWr  = 1'b0;
    RUWrEn  = 1'b0;
    PCWr    = 1'b0;
    retire  = 1'b0;
    case (state)
      IDLE:   if (Run) nxt = FETCH;
      FETCH: begin
        IMemReq = 1'b1;
        // ready on the deadline cycle wins over the timeout
        if (IMemReady) begin
          IRWr = 1'b1;
          nxt  = DECODE;
        end else if (wcnt == WLAST) begin
          nxt = TRAP;
        end
      end
      DECODE: nxt = legal ? EXEC : TRAP;
      EXEC: begin
        if (is_load || is_store) begin
          nxt = MEM;
        end else if (OpCode == OP_BRANCH) begin
          PCWr   = 1'b1;
          retire = 1'b1;
        end else begin
          nxt = WB;
        end
      end
      MEM: begin
        DMemReq = 1'b1;
        DMemWr  = is_store;
        if (DMemReady) begin
          if (is_store) begin
            PCWr   = 1'b1;
            retire = 1'b1;
          end else begin
            nxt = WB;
          end
        end else if (wcnt == WLAST) begin
          nxt = TRAP;
        end
      end
      WB: begin
        RUWrEn = 1'b1;
        PCWr   = 1'b1;
        retire = 1'b1;
      end
      TRAP:    nxt = TRAP;
      default: nxt = IDLE;
    endcase
    if (retire) nxt = Run ? FETCH : IDLE;
  end

  // Every entry into FETCH/MEM is a state change, so clearing on change
  // restarts the wait budget for each new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wcnt    <= '0;
      InstRet <= '0;
    end else begin
      state <= nxt;
      if (state != nxt)
        wcnt <= '0;
      else if ((state == FETCH && !IMemReady) || (state == MEM && !DMemReady))
        wcnt <= wcnt + CW'(1);
      if (retire)
        InstRet <= InstRet + 32'd1;
    end
  end

  assign Trap  = (state == TRAP);
  assign State = state;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multicycle sequencer for the RISC-V datapath. It steps each instruction through fetch, decode, execute, memory and write-back phases, and runs the req/ready handshakes with instruction and data memory. Its phase enables (PCWr, IRWr, RUWrEn, DMem*) gate the registers of the existing datapath, which stays decoded by ControlUnit. It also flags illegal opcodes and memory timeouts, and counts retired instructions.

## Interface
Parameters:
- TIMEOUT, default 16: maximum number of wait cycles in FETCH or MEM before trapping (≥1).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- Run  in  1  start/continue enable, sampled in IDLE and at retire.
- OpCode  in  7  instruction[6:0] from IR; valid from DECODE onward.
- IMemReady  in  1  instruction memory ready.
- DMemReady  in  1  data memory ready.
- IMemReq  out  1  instruction fetch request.
- IRWr  out  1  IR load strobe.
- DMemReq  out  1  data memory request.
- DMemWr  out  1  data memory write qualifier.
- RUWrEn  out  1  register-file write enable.
- PCWr  out  1  PC update strobe.
- Trap  out  1  sticky error flag.
- State  out  3  current state encoding.
- InstRet  out  32  retired-instruction counter.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. Encoding 7 is unreachable and recovers to IDLE.
- IDLE: all strobes 0. Run=1 → FETCH.
- FETCH:
  - IMemReq=1.
  - IMemReady=1 → IRWr=1 in the same cycle (Mealy), next state DECODE.
- DECODE: the legal OpCode set is 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Legal OpCode → EXEC.
  - Any other OpCode → TRAP.
- EXEC:
  - Load (0000011) or store (0100011) → MEM.
  - Branch (1100011) → PCWr=1, retire.
  - All other opcodes → WB.
- MEM:
  - DMemReq=1; DMemWr=1 only for a store.
  - On DMemReady for a store: PCWr=1 (Mealy), retire.
  - On DMemReady for a load: → WB.
- WB: RUWrEn=1, PCWr=1, retire.
- Retire:
  - InstRet increments by 1 and wraps from 0xFFFFFFFF to 0.
  - Next state is FETCH if Run=1, else IDLE.
- Run deasserted mid-instruction: the current instruction completes and retires, then the sequencer goes to IDLE.
- Wait counter:
  - Width is clog2(TIMEOUT+1). It clears on every entry to FETCH or MEM.
  - It increments each cycle the block stays in that state without ready.
  - If the counter equals TIMEOUT-1 and ready=0 → TRAP.
  - Ready in the deadline cycle takes priority over the trap.
- TRAP: all strobes 0, Trap=1. Terminal until rst_n asserts.
- IMemReady and DMemReady are ignored outside FETCH and MEM respectively.
- Reset values: State=IDLE, all strobes 0, Trap=0, InstRet=0, wait counter 0.

## Timing
- Reset is asynchronous: outputs reach their reset values immediately on rst_n falling, with no clock needed. The first FETCH occurs one cycle after rst_n rises with Run=1.
- Cycles per instruction with zero-wait memory (IMemReady/DMemReady high on the first request cycle):
  - Branch: 3 (FETCH, DECODE, EXEC).
  - ALU, jump, LUI, AUIPC: 4 (FETCH, DECODE, EXEC, WB).
  - Store: 4 (FETCH, DECODE, EXEC, MEM).
  - Load: 5 (FETCH, DECODE, EXEC, MEM, WB).
- Each wait cycle adds 1 cycle.
- Strobe widths: IRWr, PCWr and RUWrEn are exactly one-cycle pulses per instruction. DMemReq holds until ready.
- Back-to-back: FETCH of the next instruction is the cycle immediately after retire.
- InstRet updates on the retire edge, so it is visible in the cycle after PCWr.
- Trap asserts in the cycle after the offending DECODE or deadline cycle.

## Test plan
- Reset held, then released with Run=1, OpCode=0110011, both readies tied 1 → State sequence 1,2,3,5,1; exactly one PCWr and one RUWrEn; InstRet=1 after 4 cycles.
- Load 0000011 with DMemReady low for 3 MEM cycles → MEM lasts 4 cycles with DMemReq=1 and DMemWr=0; then WB; RUWrEn pulses once; total 8 cycles.
- Store 0100011 then branch 1100011, zero-wait → 4 + 3 cycles; DMemWr=1 only in MEM; RUWrEn never asserted; InstRet=2.
- OpCode=1111111 in DECODE → State=6 next cycle; Trap=1; no PCWr; State stays 6 while IMemReady toggles; rst_n low → Trap=0 immediately.
- TIMEOUT=4, IMemReady held low → TRAP after 4 FETCH cycles. Rerun with IMemReady rising in the 4th FETCH cycle → IRWr=1 and DECODE, no trap.
- Run dropped during EXEC of an ALU op → WB completes and InstRet increments, then State=0. Separately, rst_n asserted during MEM → State=0 and DMemReq=0 asynchronously.
